// File: rtl/mem_pkg.sv
// Shared definitions for the cache-side memory buffer: memory FSM states and request-type encoding.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WR,
        MEM_RD,
        MEM_RD_WAIT
    } mem_state;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int RQ_DEPTH = 2;

endpackage

// File: rtl/line_fifo.sv
// Compacting FIFO whose storage is fully visible: entries[0] is the head, higher indices are newer.
module line_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            valid,
    output logic [DEPTH-1:0][WIDTH-1:0] entries
);

    logic [DEPTH-1:0]            valid_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] entries_nxt;
    logic                        placed;

    assign full  = valid[DEPTH-1];
    assign empty = !valid[0];

    // Pop shifts everything one slot toward the head; a push then fills the lowest free slot.
    always_comb begin
        valid_nxt   = valid;
        entries_nxt = entries;
        placed      = 1'b0;
        if (pop && valid[0]) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                valid_nxt[i]   = valid[i+1];
                entries_nxt[i] = entries[i+1];
            end
            valid_nxt[DEPTH-1] = 1'b0;
        end
        if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!placed && !valid_nxt[i]) begin
                    valid_nxt[i]   = 1'b1;
                    entries_nxt[i] = push_data;
                    placed         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid <= '0;
        else      valid <= valid_nxt;
    end

    always_ff @(posedge clk) begin
        entries <= entries_nxt;
    end

endmodule

// File: rtl/mem_buffer.sv
// Cache-to-memory buffer: posted line writes, a 2-entry in-order read queue with
// write-buffer forwarding, and a single-outstanding-command memory FSM.
module mem_buffer
    import mem_pkg::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int PA_WIDTH   = 32,
    parameter int WB_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_enable,
    input  logic                  i_req_type,
    input  logic [PA_WIDTH-1:0]   i_req_addr,
    input  logic [LINE_WIDTH-1:0] i_req_data,
    output logic                  o_resp_enable,
    output logic [PA_WIDTH-1:0]   o_resp_addr,
    output logic [LINE_WIDTH-1:0] o_resp_data,
    input  logic                  i_resp_ack,
    output logic                  o_full,
    output logic                  o_overflow,
    output logic                  o_mem_valid,
    output logic                  o_mem_we,
    output logic [PA_WIDTH-1:0]   o_mem_addr,
    output logic [LINE_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_rvalid,
    input  logic [LINE_WIDTH-1:0] i_mem_rdata
);

    localparam int WB_WIDTH = PA_WIDTH + LINE_WIDTH;

    typedef struct packed {
        logic                  fwd;
        logic [PA_WIDTH-1:0]   addr;
        logic [LINE_WIDTH-1:0] data;
    } rq_entry_t;

    mem_state state, state_nxt;

    logic                              wb_push, wb_pop, wb_full, wb_empty;
    logic [WB_DEPTH-1:0]               wb_valid;
    logic [WB_DEPTH-1:0][WB_WIDTH-1:0] wb_entries;
    logic [PA_WIDTH-1:0]               wb_head_addr;
    logic [LINE_WIDTH-1:0]             wb_head_data;

    rq_entry_t [RQ_DEPTH-1:0] rq, rq_nxt;
    logic [RQ_DEPTH-1:0]      rq_valid, rq_valid_nxt;
    logic                     rq_push, rq_pop, rq_full;

    logic                  fwd_hit;
    logic [LINE_WIDTH-1:0] fwd_data;
    logic                  fwd_load, mem_load, drop;

    logic                  resp_valid;
    logic [PA_WIDTH-1:0]   resp_addr;
    logic [LINE_WIDTH-1:0] resp_data;
    logic                  overflow;

    assign rq_full  = rq_valid[RQ_DEPTH-1];
    assign wb_push  = i_req_enable && (i_req_type == MEM_WRITE) && !wb_full;
    assign rq_push  = i_req_enable && (i_req_type == MEM_READ) && !rq_full;
    assign drop     = i_req_enable && ((i_req_type == MEM_WRITE) ? wb_full : rq_full);
    assign wb_pop   = (state == MEM_WR) && i_mem_ready;
    assign fwd_load = rq_valid[0] && rq[0].fwd && !resp_valid;
    assign mem_load = (state == MEM_RD_WAIT) && i_mem_rvalid;
    assign rq_pop   = fwd_load || mem_load;

    assign {wb_head_addr, wb_head_data} = wb_entries[0];

    line_fifo #(
        .WIDTH (WB_WIDTH),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .push_data ({i_req_addr, i_req_data}),
        .pop       (wb_pop),
        .full      (wb_full),
        .empty     (wb_empty),
        .valid     (wb_valid),
        .entries   (wb_entries)
    );

    // Later matches override earlier ones, so the newest buffered write wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (wb_valid[i] && (wb_entries[i][WB_WIDTH-1:LINE_WIDTH] == i_req_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wb_entries[i][LINE_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rq_valid_nxt = rq_valid;
        rq_nxt       = rq;
        if (rq_pop) begin
            rq_valid_nxt = {1'b0, rq_valid[1]};
            rq_nxt[0]    = rq[1];
        end
        if (rq_push) begin
            rq_nxt[rq_valid_nxt[0]] = '{fwd: fwd_hit, addr: i_req_addr, data: fwd_data};
            rq_valid_nxt            = {rq_valid_nxt[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rq_valid <= '0;
        else      rq_valid <= rq_valid_nxt;
    end

    always_ff @(posedge clk) begin
        rq <= rq_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MEM_IDLE;
        else      state <= state_nxt;
    end

    // Reads outrank writes so a miss is not stuck behind a long write drain.
    always_comb begin
        state_nxt = state;
        case (state)
            MEM_IDLE: begin
                if (rq_valid[0] && !rq[0].fwd && !resp_valid) state_nxt = MEM_RD;
                else if (!wb_empty)                           state_nxt = MEM_WR;
            end
            MEM_WR:      if (i_mem_ready)  state_nxt = MEM_IDLE;
            MEM_RD:      if (i_mem_ready)  state_nxt = MEM_RD_WAIT;
            MEM_RD_WAIT: if (i_mem_rvalid) state_nxt = MEM_IDLE;
            default:                       state_nxt = MEM_IDLE;
        endcase
    end

    always_comb begin
        o_mem_valid = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = wb_head_addr;
        o_mem_wdata = wb_head_data;
        case (state)
            MEM_WR: begin
                o_mem_valid = 1'b1;
                o_mem_we    = 1'b1;
            end
            MEM_RD: begin
                o_mem_valid = 1'b1;
                o_mem_addr  = rq[0].addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (fwd_load || mem_load)         resp_valid <= 1'b1;
            else if (resp_valid && i_resp_ack) resp_valid <= 1'b0;
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fwd_load) begin
            resp_addr <= rq[0].addr;
            resp_data <= rq[0].data;
        end else if (mem_load) begin
            resp_addr <= rq[0].addr;
            resp_data <= i_mem_rdata;
        end
    end

    assign o_resp_enable = resp_valid;
    assign o_resp_addr   = resp_addr;
    assign o_resp_data   = resp_data;
    assign o_full        = wb_full || rq_full;
    assign o_overflow    = overflow;

endmodule

// File: tb/tb_mem_buffer.sv
// Directed bench for mem_buffer: a vector table for forwarding/read-miss timing plus
// hand-written sequences for write-buffer overflow, read priority and reset abandonment.
module tb_mem_buffer;
    import mem_pkg::*;

    localparam int LW  = 32;
    localparam int PW  = 16;
    localparam int WBD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_enable, i_req_type;
    logic [PW-1:0] i_req_addr;
    logic [LW-1:0] i_req_data;
    logic          o_resp_enable;
    logic [PW-1:0] o_resp_addr;
    logic [LW-1:0] o_resp_data;
    logic          i_resp_ack;
    logic          o_full, o_overflow;
    logic          o_mem_valid, o_mem_we;
    logic [PW-1:0] o_mem_addr;
    logic [LW-1:0] o_mem_wdata;
    logic          i_mem_ready, i_mem_rvalid;
    logic [LW-1:0] i_mem_rdata;

    always #5 clk = ~clk;

    mem_buffer #(.LINE_WIDTH(LW), .PA_WIDTH(PW), .WB_DEPTH(WBD)) dut (
        .clk(clk), .rst(rst),
        .i_req_enable(i_req_enable), .i_req_type(i_req_type),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_resp_enable(o_resp_enable), .o_resp_addr(o_resp_addr), .o_resp_data(o_resp_data),
        .i_resp_ack(i_resp_ack), .o_full(o_full), .o_overflow(o_overflow),
        .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ready(i_mem_ready),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          req_en, req_type;
        logic [PW-1:0] addr;
        logic [LW-1:0] data;
        logic          mem_ready, rvalid;
        logic [LW-1:0] rdata;
        logic          ack;
        logic          e_resp;
        logic [PW-1:0] e_raddr;
        logic [LW-1:0] e_rdata;
        logic          e_mvalid, e_we;
        logic [PW-1:0] e_maddr;
        logic [LW-1:0] e_wdata;
    } vec_t;

    vec_t vecs [25];

    logic          got_we   [$];
    logic [PW-1:0] got_addr [$];
    logic [LW-1:0] got_data [$];
    int            n_resp;
    logic [PW-1:0] resp_a;
    logic [LW-1:0] resp_d;

    function automatic vec_t mk(input logic en, input logic ty, input logic [PW-1:0] a,
                                input logic [LW-1:0] d, input logic rdy, input logic rv,
                                input logic [LW-1:0] rd, input logic ack, input logic er,
                                input logic [PW-1:0] era, input logic [LW-1:0] erd,
                                input logic emv, input logic ewe, input logic [PW-1:0] ema,
                                input logic [LW-1:0] ewd);
        vec_t v;
        v.req_en = en;   v.req_type = ty;  v.addr = a;     v.data = d;
        v.mem_ready = rdy; v.rvalid = rv;  v.rdata = rd;   v.ack = ack;
        v.e_resp = er;   v.e_raddr = era;  v.e_rdata = erd;
        v.e_mvalid = emv; v.e_we = ewe;    v.e_maddr = ema; v.e_wdata = ewd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_req_enable = v.req_en;
        i_req_type   = v.req_type;
        i_req_addr   = v.addr;
        i_req_data   = v.data;
        i_mem_ready  = v.mem_ready;
        i_mem_rvalid = v.rvalid;
        i_mem_rdata  = v.rdata;
        i_resp_ack   = v.ack;
    endtask

    task automatic idleInputs();
        i_req_enable = 1'b0; i_req_type = MEM_READ; i_req_addr = '0; i_req_data = '0;
        i_mem_ready  = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_resp_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendReq(input logic ty, input logic [PW-1:0] a, input logic [LW-1:0] d);
        i_req_enable = 1'b1; i_req_type = ty; i_req_addr = a; i_req_data = d;
        tick();
        i_req_enable = 1'b0;
    endtask

    // Memory model with ready held high: logs every command, answers reads two cycles later, acks responses.
    task automatic drain(input int cycles, input logic [LW-1:0] rdata);
        int rv_cnt;
        rv_cnt = 0;
        got_we.delete(); got_addr.delete(); got_data.delete();
        n_resp = 0;
        i_mem_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            i_mem_rvalid = 1'b0;
            i_resp_ack   = 1'b0;
            if (o_mem_valid) begin
                got_we.push_back(o_mem_we);
                got_addr.push_back(o_mem_addr);
                got_data.push_back(o_mem_wdata);
                if (!o_mem_we) rv_cnt = 2;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    i_mem_rvalid = 1'b1;
                    i_mem_rdata  = rdata;
                end
            end
            if (o_resp_enable) begin
                n_resp++;
                resp_a     = o_resp_addr;
                resp_d     = o_resp_data;
                i_resp_ack = 1'b1;
            end
            tick();
        end
        idleInputs();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic          exp_we   [4];
        logic [PW-1:0] exp_addr [4];

        vecs[0]  = mk(1, MEM_WRITE, 16'h100, 32'hA5A50001, 0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[1]  = mk(1, MEM_READ,  16'h100, 0,            0, 0, 0, 0,  0, 0, 0,                    1, 1, 16'h100, 32'hA5A50001);
        vecs[2]  = mk(0, 0, 0, 0,                          0, 0, 0, 0,  1, 16'h100, 32'hA5A50001,   1, 1, 16'h100, 32'hA5A50001);
        vecs[3]  = mk(0, 0, 0, 0,                          1, 0, 0, 1,  0, 0, 0,                    0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[5]  = mk(1, MEM_READ,  16'h200, 0,            0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    1, 0, 16'h200, 0);
        vecs[7]  = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    1, 0, 16'h200, 0);
        vecs[8]  = mk(0, 0, 0, 0,                          1, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0,                          0, 1, 32'h12345678, 0, 1, 16'h200, 32'h12345678, 0, 0, 0, 0);
        vecs[13] = mk(0, 0, 0, 0,                          0, 0, 0, 0,  1, 16'h200, 32'h12345678,   0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0,                          0, 0, 0, 0,  1, 16'h200, 32'h12345678,   0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0,                          0, 0, 0, 1,  0, 0, 0,                    0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0,                          0, 1, 32'hDEAD0000, 0, 0, 0, 0,          0, 0, 0, 0);
        vecs[17] = mk(1, MEM_WRITE, 16'h700, 32'h00000011, 0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[18] = mk(1, MEM_WRITE, 16'h700, 32'h00000022, 0, 0, 0, 0,  0, 0, 0,                    1, 1, 16'h700, 32'h00000011);
        vecs[19] = mk(1, MEM_READ,  16'h700, 0,            0, 0, 0, 0,  0, 0, 0,                    1, 1, 16'h700, 32'h00000011);
        vecs[20] = mk(0, 0, 0, 0,                          0, 0, 0, 0,  1, 16'h700, 32'h00000022,   1, 1, 16'h700, 32'h00000011);
        vecs[21] = mk(0, 0, 0, 0,                          1, 0, 0, 1,  0, 0, 0,                    0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 0,                          1, 0, 0, 0,  0, 0, 0,                    1, 1, 16'h700, 32'h00000022);
        vecs[23] = mk(0, 0, 0, 0,                          1, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);
        vecs[24] = mk(0, 0, 0, 0,                          0, 0, 0, 0,  0, 0, 0,                    0, 0, 0, 0);

        idleInputs();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("reset resp_en",   o_resp_enable, 0);
        checkOutput("reset mem_valid", o_mem_valid,   0);
        checkOutput("reset mem_we",    o_mem_we,      0);
        checkOutput("reset full",      o_full,        0);
        checkOutput("reset overflow",  o_overflow,    0);
        #2 rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d resp_en", i),   o_resp_enable, vecs[i].e_resp);
            checkOutput($sformatf("v%0d mem_valid", i), o_mem_valid,   vecs[i].e_mvalid);
            checkOutput($sformatf("v%0d full", i),      o_full,        0);
            checkOutput($sformatf("v%0d overflow", i),  o_overflow,    0);
            if (vecs[i].e_resp) begin
                checkOutput($sformatf("v%0d resp_addr", i), o_resp_addr, vecs[i].e_raddr);
                checkOutput($sformatf("v%0d resp_data", i), o_resp_data, vecs[i].e_rdata);
            end
            if (vecs[i].e_mvalid) begin
                checkOutput($sformatf("v%0d mem_we", i),   o_mem_we,   vecs[i].e_we);
                checkOutput($sformatf("v%0d mem_addr", i), o_mem_addr, vecs[i].e_maddr);
                if (vecs[i].e_we) checkOutput($sformatf("v%0d mem_wdata", i), o_mem_wdata, vecs[i].e_wdata);
            end
        end
        idleInputs();

        // Fill the write buffer while memory stalls, overflow it, then drain.
        for (int i = 0; i < 4; i++) sendReq(MEM_WRITE, 16'h400 + 16'(i), 32'h1000 + 32'(i));
        checkOutput("wb4 full",     o_full,      1);
        checkOutput("wb4 overflow", o_overflow,  0);
        checkOutput("wb4 mem_addr", o_mem_addr,  16'h400);
        sendReq(MEM_WRITE, 16'h404, 32'h1004);
        checkOutput("wb5 overflow", o_overflow, 1);
        checkOutput("wb5 full",     o_full,     1);
        drain(16, 32'h0);
        checkOutput("wb drain count", got_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_addr.size()) begin
                checkOutput($sformatf("wb drain %0d we", i),   got_we[i],   1);
                checkOutput($sformatf("wb drain %0d addr", i), got_addr[i], 16'h400 + 16'(i));
                checkOutput($sformatf("wb drain %0d data", i), got_data[i], 32'h1000 + 32'(i));
            end
        end
        checkOutput("wb drained full",   o_full,     0);
        checkOutput("wb sticky overflow", o_overflow, 1);

        // A read miss behind pending writes is issued as soon as the current write completes.
        sendReq(MEM_WRITE, 16'h500, 32'h5000);
        sendReq(MEM_WRITE, 16'h501, 32'h5001);
        sendReq(MEM_WRITE, 16'h502, 32'h5002);
        sendReq(MEM_READ,  16'h300, 32'h0);
        drain(20, 32'hC0DE0300);
        exp_we[0] = 1'b1; exp_addr[0] = 16'h500;
        exp_we[1] = 1'b0; exp_addr[1] = 16'h300;
        exp_we[2] = 1'b1; exp_addr[2] = 16'h501;
        exp_we[3] = 1'b1; exp_addr[3] = 16'h502;
        checkOutput("prio cmd count", got_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_addr.size()) begin
                checkOutput($sformatf("prio cmd %0d we", i),   got_we[i],   exp_we[i]);
                checkOutput($sformatf("prio cmd %0d addr", i), got_addr[i], exp_addr[i]);
            end
        end
        checkOutput("prio resp count", n_resp, 1);
        checkOutput("prio resp addr",  resp_a, 16'h300);
        checkOutput("prio resp data",  resp_d, 32'hC0DE0300);

        // Reset while waiting for read data; the late data must be ignored.
        i_mem_ready = 1'b1;
        sendReq(MEM_READ, 16'h600, 32'h0);
        tick();
        checkOutput("rst-seq rd valid", o_mem_valid, 1);
        checkOutput("rst-seq rd we",    o_mem_we,    0);
        checkOutput("rst-seq rd addr",  o_mem_addr,  16'h600);
        tick();
        checkOutput("rst-seq wait valid", o_mem_valid, 0);
        rst = 1'b0;
        #2;
        checkOutput("mid-reset resp_en",   o_resp_enable, 0);
        checkOutput("mid-reset mem_valid", o_mem_valid,   0);
        checkOutput("mid-reset mem_we",    o_mem_we,      0);
        checkOutput("mid-reset overflow",  o_overflow,    0);
        checkOutput("mid-reset full",      o_full,        0);
        i_mem_ready = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0BAD0;
        tick();
        i_mem_rvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput($sformatf("post-reset %0d resp_en", i),   o_resp_enable, 0);
            checkOutput($sformatf("post-reset %0d mem_valid", i), o_mem_valid,   0);
            checkOutput($sformatf("post-reset %0d full", i),      o_full,        0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
